// File: rtl/ghr_checkpoint_ctrl_if.sv
// ghr_checkpoint_ctrl_if
//   Bundles the predict, resolve, flush and history/redirect signals of the
//   speculative global-history controller.
//   master : the front-end/back-end side (drives predict/resolve/flush,
//            observes ready, tag, histories, count and redirect)
//   slave  : the controller itself
interface ghr_checkpoint_ctrl_if #(
  parameter int unsigned GHR_W = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = $clog2(DEPTH)
);
  logic             predict_v_i;
  logic             predict_taken_i;
  logic             predict_ready_o;
  logic [TAG_W-1:0] predict_tag_o;
  logic             resolve_v_i;
  logic [TAG_W-1:0] resolve_tag_i;
  logic             resolve_taken_i;
  logic             flush_i;
  logic [GHR_W-1:0] ghr_o;
  logic [GHR_W-1:0] committed_ghr_o;
  logic [TAG_W:0]   count_o;
  logic             redirect_v_o;
  logic             redirect_taken_o;

  modport master (
    output predict_v_i, predict_taken_i, resolve_v_i, resolve_tag_i,
           resolve_taken_i, flush_i,
    input  predict_ready_o, predict_tag_o, ghr_o, committed_ghr_o, count_o,
           redirect_v_o, redirect_taken_o
  );

  modport slave (
    input  predict_v_i, predict_taken_i, resolve_v_i, resolve_tag_i,
           resolve_taken_i, flush_i,
    output predict_ready_o, predict_tag_o, ghr_o, committed_ghr_o, count_o,
           redirect_v_o, redirect_taken_o
  );
endinterface

// File: rtl/ghr_checkpoint_ctrl.sv
// ghr_checkpoint_ctrl
//   Speculative/committed global-history controller with a circular
//   checkpoint queue (one entry per in-flight predicted branch).
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     bus  - ghr_checkpoint_ctrl_if.slave: predict handshake (v/taken/ready/
//            tag), out-of-order resolve by tag, flush, speculative and
//            committed history, in-flight count, registered redirect pulse.
//   History shift: new bit enters at the MSB, history moves right.
module ghr_checkpoint_ctrl #(
  parameter int unsigned GHR_W = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst,
  ghr_checkpoint_ctrl_if.slave bus
);

  logic [GHR_W-1:0] spec_q, spec_d;
  logic [GHR_W-1:0] comm_q, comm_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [DEPTH-1:0] pred_q, pred_d;
  logic [DEPTH-1:0] outcome_q, outcome_d;
  logic [GHR_W-1:0] ckpt_q [DEPTH];
  logic [GHR_W-1:0] ckpt_d [DEPTH];
  logic             redir_v_q, redir_v_d;
  logic             redir_t_q, redir_t_d;

  logic             ready;
  logic             push;
  logic             res_hit;
  logic             mispredict;
  logic             commit;
  logic [TAG_W-1:0] off_t;

  // Ready depends only on the registered count.
  assign ready      = (count_q != (TAG_W+1)'(DEPTH));
  assign push       = bus.predict_v_i && ready;
  assign res_hit    = bus.resolve_v_i && valid_q[bus.resolve_tag_i] &&
                      !resolved_q[bus.resolve_tag_i];
  assign mispredict = res_hit && (bus.resolve_taken_i != pred_q[bus.resolve_tag_i]);
  // resolved_q is registered, so commit always trails resolve by a cycle.
  assign commit     = valid_q[head_q] && resolved_q[head_q] && !bus.flush_i;
  // Age of the resolving branch relative to the oldest in-flight branch.
  assign off_t      = bus.resolve_tag_i - head_q;

  always_comb begin
    spec_d     = spec_q;
    comm_d     = comm_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + (TAG_W+1)'(push) - (TAG_W+1)'(commit);
    valid_d    = valid_q;
    resolved_d = resolved_q;
    pred_d     = pred_q;
    outcome_d  = outcome_q;
    ckpt_d     = ckpt_q;
    redir_v_d  = 1'b0;
    redir_t_d  = redir_t_q;

    if (commit) begin
      comm_d          = {outcome_q[head_q], comm_q[GHR_W-1:1]};
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (res_hit) begin
      resolved_d[bus.resolve_tag_i] = 1'b1;
      outcome_d[bus.resolve_tag_i]  = bus.resolve_taken_i;
    end

    if (push) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      pred_d[tail_q]     = bus.predict_taken_i;
      ckpt_d[tail_q]     = spec_q;
      spec_d             = {bus.predict_taken_i, spec_q[GHR_W-1:1]};
      tail_d             = tail_q + 1'b1;
    end

    // Everything younger than the mispredicted branch is squashed, which
    // also covers an entry pushed in this same cycle (it sits at offset
    // count_q, always beyond off_t). The head can never be squashed here.
    if (mispredict) begin
      spec_d = {bus.resolve_taken_i, ckpt_q[bus.resolve_tag_i][GHR_W-1:1]};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (TAG_W'(TAG_W'(i) - head_q) > off_t) valid_d[i] = 1'b0;
      end
      tail_d    = bus.resolve_tag_i + 1'b1;
      count_d   = (TAG_W+1)'(off_t) + (TAG_W+1)'(1) - (TAG_W+1)'(commit);
      redir_v_d = 1'b1;
      redir_t_d = bus.resolve_taken_i;
    end

    if (bus.flush_i) begin
      valid_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      spec_d    = comm_q;
      redir_v_d = 1'b0;
      redir_t_d = redir_t_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_q     <= '0;
      comm_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
      pred_q     <= '0;
      outcome_q  <= '0;
      ckpt_q     <= '{default: '0};
      redir_v_q  <= 1'b0;
      redir_t_q  <= 1'b0;
    end else begin
      spec_q     <= spec_d;
      comm_q     <= comm_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      pred_q     <= pred_d;
      outcome_q  <= outcome_d;
      ckpt_q     <= ckpt_d;
      redir_v_q  <= redir_v_d;
      redir_t_q  <= redir_t_d;
    end
  end

  assign bus.predict_ready_o  = ready;
  assign bus.predict_tag_o    = tail_q;
  assign bus.ghr_o            = spec_q;
  assign bus.committed_ghr_o  = comm_q;
  assign bus.count_o          = count_q;
  assign bus.redirect_v_o     = redir_v_q;
  assign bus.redirect_taken_o = redir_t_q;

endmodule
